inv_sbox_seq: RTL and testbench
===============================

Name: inv_sbox_seq

Overview:
- Sequential AES inverse S-box for the decryption datapath; it is the counterpart of the forward S-box.
- Applies the inverse affine transform, then finds the GF(2^8) multiplicative inverse by walking generator 0x03 forward and its inverse 0xF6 in lockstep until the forward walk matches.
- One byte per transaction, with a start/ready/valid handshake.
- Sits in InvSubBytes of the AES-128 decrypt round, instantiated per byte lane or time-shared by a byte sequencer.

Parameters:
- none (the field is fixed: polynomial 0x11B, generator 0x03)

Ports:
- clk      input   1  rising-edge clock
- rst_n    input   1  asynchronous active-low reset
- i_start  input   1  request; accepted only when o_ready=1
- i_data   input   8  S-box output byte to invert; sampled at acceptance
- o_ready  output  1  high in IDLE; a request is accepted when i_start=1 and o_ready=1
- o_valid  output  1  one-cycle pulse when o_data is new
- o_data   output  8  InvSbox(i_data); holds until the next result

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, o_ready=1, o_valid=0, o_data=0x00, fwd=0x01, rev=0x01, y=0x00.
- Inverse affine, combinational on i_data, with index mod 8: y[i] = d[i+2] ^ d[i+5] ^ d[i+7] ^ c[i], where c=0x05.
- States: IDLE, SEARCH.
- IDLE:
  - On an accepted i_start at edge E0: register y; set fwd=0x01, rev=0x01; go to SEARCH.
  - o_ready=0 from E0 until the result edge.
- SEARCH, cycle n: fwd=3^n and rev=3^(255-n) mod 255.
  - If y==0x00: o_data<=0x00, o_valid<=1, go to IDLE.
  - Else if fwd==y: o_data<=rev, o_valid<=1, go to IDLE.
  - Else: fwd<=fwd·0x03, rev<=rev·0xF6 (both constant GF multiplies, reduced mod 0x11B), stay in SEARCH.
- Latency: for y≠0, with k=log3(y) in 0..254, the result registers at edge E(k+1).
  - o_valid is high in the cycle after E(k+1); o_ready returns to 1 in that same cycle.
  - For y==0 the latency is 1 (result at E1). Maximum latency is 255.
- o_valid is a single cycle. A new i_start in the o_valid cycle is accepted (back-to-back, no bubble).
- i_start while o_ready=0 is ignored; no queueing.
- SEARCH always terminates within 255 cycles: 0x03 generates GF(2^8)*, and y==0 exits immediately.
- Reset mid-SEARCH: abort immediately, return to IDLE.
  - o_data=0x00 and o_valid=0; no partial result is ever emitted.

Decomposition:
- Shared package aes_pkg:
  - constants GF_POLY=8'h1B, GEN=8'h03, GEN_INV=8'hF6, INV_AFFINE_C=8'h05
  - function xtime
  - function gf_mul_const (used by the forward S-box rework as well)
  - function inv_affine
- Sub-module gf_log_walker: holds fwd/rev, step and compare, and reports match.
  - It is the only natural split; the rest is handshake and control.

Test Plan:
- Reset mid-SEARCH: start 0x7B, assert rst_n=0 at cycle 10 -> o_valid never pulses, o_data=0x00, o_ready=1 after release; a new start 0x7C then returns 0x01.
- i_data=0x63 -> y=0x00; o_valid one cycle after acceptance, o_data=0x00.
- i_data=0x7C -> y=0x01, k=0; latency 1, o_data=0x01. Then i_data=0x00 -> latency 3 (y=0x05=3^2), o_data=0x52.
- i_data=0x7B -> y=0xF6, worst case k=254; o_valid exactly 255 cycles after acceptance, o_data=0x03; o_ready=0 throughout.
- i_data=0xED -> o_data=0x53. Pulse i_start with 0x11 mid-search -> ignored, result still 0x53. Start 0xFF in the o_valid cycle -> accepted, o_data=0x7D.
- Exhaustive sweep of all 256 inputs with back-to-back starts:
  - every result matches the FIPS-197 inverse table;
  - exactly one o_valid per accepted start;
  - measured latency equals log3(y)+1.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES field constants and GF(2^8) helpers
package aes_pkg;

    localparam logic [7:0] GF_POLY      = 8'h1B;
    localparam logic [7:0] GEN          = 8'h03;
    localparam logic [7:0] GEN_INV      = 8'hF6;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } inv_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // y[i] = d[i+2] ^ d[i+5] ^ d[i+7] ^ c[i] is a sum of right rotations by 2, 5 and 7
    function automatic logic [7:0] inv_affine(input logic [7:0] d);
        return {d[1:0], d[7:2]} ^ {d[4:0], d[7:5]} ^ {d[6:0], d[7]} ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/gf_log_walker.sv
// rtl/gf_log_walker.sv - lockstep walk of 3^n and 3^-n with match against target
module gf_log_walker
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [7:0] i_target,
    output logic       o_match,
    output logic [7:0] o_rev
);

    logic [7:0] fwd_q, fwd_d;
    logic [7:0] rev_q, rev_d;

    always_comb begin
        fwd_d = fwd_q;
        rev_d = rev_q;
        if (i_load) begin
            fwd_d = 8'h01;
            rev_d = 8'h01;
        end else if (i_step) begin
            fwd_d = gf_mul_const(fwd_q, GEN);
            rev_d = gf_mul_const(rev_q, GEN_INV);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= 8'h01;
            rev_q <= 8'h01;
        end else begin
            fwd_q <= fwd_d;
            rev_q <= rev_d;
        end
    end

    // rev is always the multiplicative inverse of fwd, so it is the answer on a match
    assign o_match = (fwd_q == i_target);
    assign o_rev   = rev_q;

endmodule

// File: rtl/inv_sbox_seq.sv
// rtl/inv_sbox_seq.sv - sequential AES inverse S-box with start/ready/valid handshake
module inv_sbox_seq
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_valid,
    output logic [7:0] o_data
);

    inv_state_e state_q, state_d;
    logic [7:0] y_q, y_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    logic       accept;
    logic       y_zero;
    logic       match;
    logic       done;
    logic       step;
    logic [7:0] rev;

    assign accept = i_start && (state_q == ST_IDLE);
    assign y_zero = (y_q == 8'h00);
    assign done   = (state_q == ST_SEARCH) && (y_zero || match);
    assign step   = (state_q == ST_SEARCH) && !done;

    gf_log_walker u_walker (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (accept),
        .i_step   (step),
        .i_target (y_q),
        .o_match  (match),
        .o_rev    (rev)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SEARCH;
            ST_SEARCH: if (done)   state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        y_d     = accept ? inv_affine(i_data) : y_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (done) begin
            data_d  = y_zero ? 8'h00 : rev;
            valid_d = 1'b1;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_inv_sbox_seq.sv
// tb/tb_inv_sbox_seq.sv - scoreboard bench for inv_sbox_seq against a table-built reference
module tb_inv_sbox_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_ready;
    logic       o_valid;
    logic [7:0] o_data;

    always #5 clk = ~clk;

    inv_sbox_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data)
    );

    typedef struct {
        int din;
        int exp;
        int lat;
        int acc;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_data = 0;
    int   inv_tab[256];
    int   log3[256];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gmul(int a, int b);
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            if (b & 1) r = r ^ a;
            a = a << 1;
            if (a & 'h100) a = a ^ 'h11B;
            b = b >> 1;
        end
        return r;
    endfunction

    function automatic int ginv(int a);
        if (a == 0) return 0;
        for (int b = 1; b < 256; b++)
            if (gmul(a, b) == 1) return b;
        return 0;
    endfunction

    function automatic int rotl(int x, int n);
        return ((x << n) | (x >> (8 - n))) & 255;
    endfunction

    // Expected latency follows from y = multiplicative inverse of the result byte
    function automatic int lat_of(int d);
        int y;
        y = ginv(inv_tab[d]);
        return (y == 0) ? 1 : log3[y] + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int d);
        int n = 0;
        while (!o_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 400) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout actual=busy required=ready");
                return;
            end
        end
        i_start = 1'b1;
        i_data  = d[7:0];
        sb.push_back('{d, inv_tab[d], lat_of(d), cyc + 1});
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
        step_cycles(2);
    endtask

    always @(negedge clk) begin
        bit   active;
        txn_t t;
        active = 1'b0;
        if (sb.size() > 0) active = (sb[0].acc <= cyc);
        if (o_valid) begin
            if (!active) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid actual=1 required=0 data=%0h", o_data);
            end else begin
                t = sb.pop_front();
                check($sformatf("data_%02h", t.din), int'(o_data), t.exp);
                check($sformatf("lat_%02h", t.din), cyc - t.acc, t.lat);
                last_data = t.exp;
            end
            check("ready_in_valid", int'(o_ready), 1);
        end else begin
            check("ready_level", int'(o_ready), active ? 0 : 1);
            check("data_hold", int'(o_data), last_data);
        end
    end

    initial begin
        int order[256];
        int p;
        int j;
        int tmp;
        int s;
        for (int a = 0; a < 256; a++) begin
            int b;
            b = ginv(a);
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 'h63;
            inv_tab[s] = a;
        end
        log3[0] = 0;
        p = 1;
        for (int k = 0; k < 255; k++) begin
            log3[p] = k;
            p = gmul(p, 3);
        end

        step_cycles(3);
        check("reset_ready", int'(o_ready), 1);
        check("reset_valid", int'(o_valid), 0);
        check("reset_data", int'(o_data), 0);
        rst_n = 1'b1;
        step_cycles(2);

        // Reset in the middle of the longest search
        issue('h7B);
        step_cycles(9);
        rst_n = 1'b0;
        sb.delete();
        last_data = 0;
        step_cycles(2);
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_data", int'(o_data), 0);
        check("midrst_ready", int'(o_ready), 1);
        rst_n = 1'b1;
        step_cycles(3);
        check("post_rst_ready", int'(o_ready), 1);
        issue('h7C);
        drain();

        issue('h63);
        drain();
        issue('h7C);
        issue('h00);
        drain();
        issue('h7B);
        drain();

        issue('hED);
        i_start = 1'b1;
        i_data  = 8'h11;
        step_cycles(1);
        i_start = 1'b0;
        issue('hFF);
        drain();

        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) issue(order[i]);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                drain();
                step_cycles($urandom_range(0, 3));
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
